// File: rtl/inv_sbox_word.sv
// rtl/inv_sbox_word.sv - word-wide AES InvSubBytes through one time-shared byte S-box
// Optional macro INV_SBOX_FWD_EN adds a per-word fwd input selecting the forward S-box.
module inv_sbox_word (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
`ifdef INV_SBOX_FWD_EN
    input  logic        fwd,
`endif
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [31:0] word;
    logic [31:0] result;
    logic [7:0]  sbox_in;
    logic [7:0]  sbox_out;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (x & {8{b[i]}});
            x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
        end
        return p;
    endfunction

    // a^254 equals a^-1 for nonzero a and yields 0 for a = 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

`ifdef INV_SBOX_FWD_EN
    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic       fwd_q;
    logic [7:0] inv_in;
    logic [7:0] inv_out;

    // Affine stages wrap the single inverter so both directions share it
    always_comb begin
        inv_in   = fwd_q ? sbox_in : inv_affine(sbox_in);
        inv_out  = gf_inv(inv_in);
        sbox_out = fwd_q ? fwd_affine(inv_out) : inv_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            fwd_q <= fwd;
        end
    end
`else
    always_comb begin
        sbox_out = gf_inv(inv_affine(sbox_in));
    end
`endif

    assign sbox_in = word[{cnt, 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (cnt == 2'd3) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // out_data is only updated when the last byte lands, so partial results never show
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 2'd0;
            word     <= 32'h0;
            result   <= 32'h0;
            out_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word <= in_data;
                        cnt  <= 2'd0;
                    end
                end
                BUSY: begin
                    result[{cnt, 3'b000} +: 8] <= sbox_out;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) out_data <= {sbox_out, result[23:0]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sbox_word.sv
// tb/tb_inv_sbox_word.sv - scoreboard bench for inv_sbox_word against a table-based AES model
module tb_inv_sbox_word;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef INV_SBOX_FWD_EN
    logic        fwd = 1'b0;
`endif

    inv_sbox_word dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
`ifdef INV_SBOX_FWD_EN
        .fwd(fwd),
`endif
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    logic [7:0]  fwd_tbl[256];
    logic [7:0]  inv_tbl[256];
    logic        prev_ov = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) p ^= a;
            a = a << 1;
            if (a & 'h100) a ^= 'h11b;
        end
        return p;
    endfunction

    // Forward S-box from brute-force inverse plus the bitwise affine rule; inverse table by reversal
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            int s = 0;
            for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
            for (int i = 0; i < 8; i++) begin
                int bit_v = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                           ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
                s |= bit_v << i;
            end
            fwd_tbl[x] = 8'(s);
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input bit f);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = f ? fwd_tbl[d[k*8 +: 8]] : inv_tbl[d[k*8 +: 8]];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - acc_q[0]), 32'd4);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", out_data, 32'hxxxxxxxx);
                end else begin
                    chk("data", out_data, exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic send_word(input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int pushed;
        int vcount;
        build_tables();

        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        out_ready = 1'b1;
        send_word(32'h637C16ED, 32'h0001FF53);
        drain();
        chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
        send_word(32'h00000000, 32'h52525252);
        send_word(32'h52525252, 32'h48484848);
        drain();

        out_ready = 1'b0;
        send_word(32'h00000000, 32'h52525252);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        for (int n = 0; n < 10; n++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", out_data, 32'h52525252);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_hold_result", out_data, 32'h52525252);

        send_word(32'h12345678, model(32'h12345678, 1'b0));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_data", out_data, 32'h0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        vcount = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (out_valid) vcount++;
        end
        chk("abort_no_valid", 32'(vcount), 32'd0);
        send_word(32'h7C7C7C7C, 32'h01010101);
        drain();

`ifdef INV_SBOX_FWD_EN
        fwd = 1'b1;
        send_word(32'h0001FF53, 32'h637C16ED);
        drain();
        for (int w = 0; w < 64; w++) begin
            logic [31:0] d;
            d = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            fwd = 1'b1;
            send_word(d, model(d, 1'b1));
            fwd = 1'b0;
            send_word(model(d, 1'b1), d);
        end
        drain();
`endif

        pushed = 0;
        for (int n = 0; n < 20000 && pushed < 1000; n++) begin
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom);
`ifdef INV_SBOX_FWD_EN
            fwd = 1'($urandom);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, fwd));
`else
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, 1'b0));
`endif
                acc_q.push_back(cyc + 1);
                pushed++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("random_issued", 32'(pushed), 32'd1000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
